// File: rtl/bitonic_intersect_pe.sv
// Pipelined set-intersection PE: merges two ascending rule-ID sets through a bitonic
// half-cleaner network, then compacts adjacent equal nonzero IDs into an ascending result.
module bitonic_intersect_pe #(
    parameter int ID_W  = 4,
    parameter int N     = 8,
    parameter int TAG_W = 8,
    parameter int CNT_W = $clog2(N+1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*ID_W-1:0]   in_a,
    input  logic [N*ID_W-1:0]   in_b,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*ID_W-1:0]   out_ids,
    output logic [CNT_W-1:0]    out_cnt,
    output logic [TAG_W-1:0]    out_tag
);
    localparam int M     = 2 * N;
    localparam int NST   = $clog2(M);
    localparam int IDX_W = $clog2(N);

    typedef logic [M-1:0][ID_W-1:0] seq_t;

    seq_t                   st_q [NST+1];
    seq_t                   st_d [NST+1];
    logic [NST:0]           vld_q;
    logic [TAG_W-1:0]       tag_q [NST+1];

    logic                   out_valid_q;
    logic [N-1:0][ID_W-1:0] ids_q;
    logic [N-1:0][ID_W-1:0] ids_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [TAG_W-1:0]       otag_q;
    logic                   en;

    // One global enable: the whole pipe advances only when the output slot can move.
    assign en       = out_ready | ~out_valid_q;
    assign in_ready = en;

    // A ascending followed by B reversed is a bitonic sequence of 2N entries.
    for (genvar i = 0; i < N; i++) begin : g_cap
        assign st_d[0][i]   = in_a[i*ID_W +: ID_W];
        assign st_d[0][N+i] = in_b[(N-1-i)*ID_W +: ID_W];
    end

    for (genvar k = 1; k <= NST; k++) begin : g_hc
        localparam int D = M >> k;
        for (genvar p = 0; p < N; p++) begin : g_cx
            localparam int LO = (p / D) * 2 * D + (p % D);
            localparam int HI = LO + D;
            logic swap;
            // Strict compare: equal values stay in place.
            assign swap          = st_q[k-1][HI] < st_q[k-1][LO];
            assign st_d[k][LO]   = swap ? st_q[k-1][HI] : st_q[k-1][LO];
            assign st_d[k][HI]   = swap ? st_q[k-1][LO] : st_q[k-1][HI];
        end
    end

    // Sorted sequence: an ID present in both sets appears as an adjacent equal pair.
    always_comb begin
        logic [CNT_W-1:0] pos;
        ids_d = '0;
        pos   = '0;
        for (int j = 0; j < M-1; j++) begin
            if ((st_q[NST][j] == st_q[NST][j+1]) && (st_q[NST][j] != '0)) begin
                if (pos < CNT_W'(N)) begin
                    ids_d[pos[IDX_W-1:0]] = st_q[NST][j];
                end
                pos = pos + 1'b1;
            end
        end
        cnt_d = pos;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= NST; k++) begin
                st_q[k]  <= '0;
                tag_q[k] <= '0;
            end
            vld_q <= '0;
        end else if (en) begin
            for (int k = 0; k <= NST; k++) begin
                st_q[k] <= st_d[k];
            end
            tag_q[0] <= in_tag;
            for (int k = 1; k <= NST; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            vld_q <= {vld_q[NST-1:0], in_valid};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            ids_q       <= '0;
            cnt_q       <= '0;
            otag_q      <= '0;
        end else if (en) begin
            out_valid_q <= vld_q[NST];
            ids_q       <= ids_d;
            cnt_q       <= cnt_d;
            otag_q      <= tag_q[NST];
        end
    end

    assign out_valid = out_valid_q;
    assign out_ids   = ids_q;
    assign out_cnt   = cnt_q;
    assign out_tag   = otag_q;

endmodule
